// File: rtl/sprite_pkg.sv
// Shared sprite definitions: image size used by the renderers and the loader,
// the packed {R,G,B} pixel word and the loader state encoding.
package sprite_pkg;

    localparam int SPRITE_W = 50;
    localparam int SPRITE_H = 44;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } sprite_pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        GET_R,
        GET_G,
        GET_B,
        WRITE,
        FINISH
    } loader_state_e;

endpackage

// File: rtl/sprite_ram_loader_if.sv
// Control, byte-stream and RAM write-port bundle of the sprite RAM loader.
// master = host/bridge side, slave = loader.
interface sprite_ram_loader_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic              load_start;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] data_out;
    logic              we;
    logic              busy;
    logic              done;

    modport master (
        output load_start, abort, byte_in, byte_valid,
        input  byte_ready, write_address, data_out, we, busy, done
    );

    modport slave (
        input  load_start, abort, byte_in, byte_valid,
        output byte_ready, write_address, data_out, we, busy, done
    );
endinterface

// File: rtl/sprite_ram_loader.sv
// Fills a sprite RAM row-major from an R,G,B byte stream, one 24-bit word per
// pixel. Every output is a register so the RAM write port sees clean timing.
module sprite_ram_loader
    import sprite_pkg::*;
#(
    parameter int IMAGE_WIDTH  = SPRITE_W,
    parameter int IMAGE_HEIGHT = SPRITE_H,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 24
) (
    input logic               Clk,
    input logic               Reset_n,
    sprite_ram_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

    if (longint'(IMAGE_WIDTH) * longint'(IMAGE_HEIGHT) > (longint'(1) << ADDR_W)) begin : g_size_chk
        $error("sprite_ram_loader: image does not fit in ADDR_W address bits");
    end
    if (DATA_W != $bits(sprite_pixel_t)) begin : g_width_chk
        $error("sprite_ram_loader: DATA_W must match the {R,G,B} pixel width");
    end

    loader_state_e     r_state;
    loader_state_e     w_next;
    logic              w_accept;
    logic [ADDR_W-1:0] r_addr;
    sprite_pixel_t     r_pix;
    logic              r_byte_ready;
    logic              r_we;
    logic              r_busy;
    logic              r_done;

    // abort wins over everything, including the byte that would complete a pixel
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        if (r_state != IDLE && bus.abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:   if (bus.load_start) w_next = GET_R;
                GET_R:  if (bus.byte_valid) begin w_accept = 1'b1; w_next = GET_G; end
                GET_G:  if (bus.byte_valid) begin w_accept = 1'b1; w_next = GET_B; end
                GET_B:  if (bus.byte_valid) begin w_accept = 1'b1; w_next = WRITE; end
                WRITE:  w_next = (r_addr == LAST_ADDR) ? FINISH : GET_R;
                FINISH: w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Outputs are registered decodes of the next state, so they line up with r_state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr       <= '0;
            r_pix        <= '0;
        end else begin
            r_byte_ready <= (w_next == GET_R) || (w_next == GET_G) || (w_next == GET_B);
            r_we         <= (w_next == WRITE);
            r_busy       <= (w_next != IDLE);
            r_done       <= (w_next == FINISH);

            if (r_state == IDLE && bus.load_start)
                r_addr <= '0;
            else if (r_state == WRITE && w_next == GET_R)
                r_addr <= r_addr + ADDR_W'(1);

            if (w_accept) begin
                case (r_state)
                    GET_R:   r_pix.r <= bus.byte_in;
                    GET_G:   r_pix.g <= bus.byte_in;
                    GET_B:   r_pix.b <= bus.byte_in;
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready    = r_byte_ready;
    assign bus.write_address = r_addr;
    assign bus.data_out      = r_pix;
    assign bus.we            = r_we;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Randomised bench for sprite_ram_loader: a pixel-level reference model and a
// RAM image are compared against the DUT every cycle, plus literal checkpoints.
module tb_sprite_ram_loader;
    import sprite_pkg::*;

    localparam int W    = SPRITE_W;
    localparam int H    = SPRITE_H;
    localparam int AW   = 19;
    localparam int DW   = 24;
    localparam int NPIX = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_ram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_ram_loader #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .bus(bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model: loader seen as "bytes collected for the current pixel"
    bit          m_busy, m_fin;
    int          m_nb, m_pix;
    logic [7:0]  m_rgb [3];

    // byte source and observers
    int          k, k_lim, duty;
    bit          src_en;
    logic [DW-1:0] mem [NPIX];
    bit          wr  [NPIX];
    int          exp_addr, acc_cnt, n_wr, n_done;
    int          t0, tdone, guard;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] stream_byte(input int idx);
        int p;
        p = idx / 3;
        if (idx % 3 == 0) return p[7:0];
        if (idx % 3 == 1) return 8'hA5;
        return 8'h3C;
    endfunction

    function automatic logic [23:0] pix_word(input int a);
        return {a[7:0], 8'hA5, 8'h3C};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_fin = 0; m_nb = 0; m_pix = 0;
        m_rgb[0] = 8'h00; m_rgb[1] = 8'h00; m_rgb[2] = 8'h00;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (bus.load_start) begin m_busy = 1; m_fin = 0; m_nb = 0; m_pix = 0; end
        end else if (bus.abort) begin
            m_busy = 0; m_fin = 0;
        end else if (m_fin) begin
            m_busy = 0; m_fin = 0;
        end else if (m_nb == 3) begin
            if (m_pix == NPIX - 1) m_fin = 1;
            else begin m_pix++; m_nb = 0; end
        end else if (bus.byte_valid) begin
            m_rgb[m_nb] = bus.byte_in;
            m_nb++;
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < NPIX; a++) begin mem[a] = '0; wr[a] = 0; end
        n_wr = 0; n_done = 0;
    endtask

    // One clock: compare at the falling edge, advance the model over the rising edge,
    // then drive the next inputs 1 time unit after it.
    task automatic tick();
        bit acc;
        @(negedge clk);
        check("busy",          64'(bus.busy),          64'(m_busy));
        check("byte_ready",    64'(bus.byte_ready),    64'(m_busy && !m_fin && m_nb < 3));
        check("we",            64'(bus.we),            64'(m_busy && !m_fin && m_nb == 3));
        check("done",          64'(bus.done),          64'(m_busy && m_fin));
        check("write_address", 64'(bus.write_address), 64'(m_pix));
        check("data_out",      64'(bus.data_out),      64'({m_rgb[0], m_rgb[1], m_rgb[2]}));
        acc = bus.byte_valid && bus.byte_ready && !bus.abort;
        if (acc) acc_cnt++;
        if (bus.we) begin
            check("write_order",     64'(bus.write_address), 64'(exp_addr));
            check("bytes_per_write", 64'(acc_cnt),           64'd3);
            exp_addr++;
            acc_cnt = 0;
            n_wr++;
            if (bus.write_address < AW'(NPIX)) begin
                mem[bus.write_address] = bus.data_out;
                wr[bus.write_address]  = 1;
            end
        end
        if (bus.done) n_done++;
        if (rst_n && !bus.busy && bus.load_start) begin exp_addr = 0; acc_cnt = 0; end
        if (rst_n && bus.busy && bus.abort) acc_cnt = 0;
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (acc) k++;
        if (!rst_n) begin
            model_reset();
            acc_cnt = 0;
            bus.load_start = 1'($urandom_range(1));
            bus.abort      = 1'($urandom_range(1));
            bus.byte_valid = 1'($urandom_range(1));
            bus.byte_in    = 8'($urandom);
        end else begin
            bus.byte_valid = src_en && (k < k_lim) && ($urandom_range(99) < duty);
            bus.byte_in    = bus.byte_valid ? stream_byte(k) : 8'($urandom);
        end
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        t0 = cyc;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        guard = 0;
        while (!bus.done && guard < limit) begin tick(); guard++; end
        check("done_reached", 64'(bus.done), 64'd1);
        tdone = cyc;
    endtask

    task automatic check_image(input string tag);
        for (int a = 0; a < NPIX; a++)
            check(tag, {39'd0, wr[a], mem[a]}, {39'd0, 1'b1, pix_word(a)});
    endtask

    initial begin
        bus.load_start = 0; bus.abort = 0; bus.byte_valid = 0; bus.byte_in = 0;
        k = 0; k_lim = 3 * NPIX; duty = 100; src_en = 0;
        exp_addr = 0; acc_cnt = 0;
        model_reset();
        clear_mem();

        // reset held with random inputs
        repeat (8) tick();
        check("rst_we",    64'(bus.we),            64'd0);
        check("rst_busy",  64'(bus.busy),          64'd0);
        check("rst_ready", 64'(bus.byte_ready),    64'd0);
        check("rst_done",  64'(bus.done),          64'd0);
        check("rst_addr",  64'(bus.write_address), 64'd0);
        check("rst_data",  64'(bus.data_out),      64'd0);
        bus.load_start = 0; bus.abort = 0; bus.byte_valid = 0;
        rst_n = 1'b1;
        repeat (3) tick();

        // full image, no stalls
        clear_mem(); k = 0; src_en = 1; duty = 100;
        start_load();
        check("start_busy",  64'(bus.busy),       64'd1);
        check("start_ready", 64'(bus.byte_ready), 64'd1);
        wait_done(10000);
        check("load_cycles", 64'(tdone - t0), 64'd8801);
        tick();
        check("idle_busy_after_done", 64'(bus.busy), 64'd0);
        check("n_writes_full", 64'(n_wr),   64'd2200);
        check("n_done_full",   64'(n_done), 64'd1);
        check("mem0",    64'(mem[0]),    64'h00A53C);
        check("mem255",  64'(mem[255]),  64'hFFA53C);
        check("mem2199", 64'(mem[2199]), 64'h97A53C);
        check_image("ram_full");

        // ~50% byte_valid gaps, load_start re-pulsed around pixel 100
        clear_mem(); k = 0; duty = 50;
        start_load();
        guard = 0;
        while (exp_addr < 100 && guard < 5000) begin tick(); guard++; end
        check("reached_px100", 64'(exp_addr), 64'd100);
        bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
        tick();
        bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
        wait_done(40000);
        tick();
        check("n_writes_gaps", 64'(n_wr),   64'd2200);
        check("n_done_gaps",   64'(n_done), 64'd1);
        check_image("ram_gaps");

        // abort after the G byte of pixel 7, with the B byte on offer
        clear_mem(); k = 0; k_lim = 3 * 7 + 2; duty = 100;
        start_load();
        guard = 0;
        while (!(k == k_lim && bus.byte_ready) && guard < 200) begin tick(); guard++; end
        check("abort_setup_k", 64'(k), 64'(3 * 7 + 2));
        src_en = 0;
        bus.abort = 1'b1; bus.byte_valid = 1'b1; bus.byte_in = stream_byte(k);
        tick();
        bus.abort = 1'b0;
        check("abort_busy",  64'(bus.busy),       64'd0);
        check("abort_ready", 64'(bus.byte_ready), 64'd0);
        check("abort_we",    64'(bus.we),         64'd0);
        repeat (6) tick();
        check("abort_no_wr7",  64'(wr[7]),  64'd0);
        check("abort_wr6",     64'(wr[6]),  64'd1);
        check("abort_n_wr",    64'(n_wr),   64'd7);
        check("abort_no_done", 64'(n_done), 64'd0);

        // reload from 0, then reset on the write cycle of pixel 500
        clear_mem(); k = 0; k_lim = 3 * NPIX; src_en = 1; duty = 100;
        start_load();
        guard = 0;
        while (!(bus.we && bus.write_address == AW'(500)) && guard < 5000) begin tick(); guard++; end
        check("reload_mem0", 64'(mem[0]), 64'h00A53C);
        check("we_px500",    64'(bus.we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_we",    64'(bus.we),            64'd0);
        check("async_busy",  64'(bus.busy),          64'd0);
        check("async_ready", 64'(bus.byte_ready),    64'd0);
        check("async_addr",  64'(bus.write_address), 64'd0);
        check("async_data",  64'(bus.data_out),      64'd0);
        model_reset();
        repeat (3) tick();
        bus.load_start = 0; bus.abort = 0; bus.byte_valid = 0;
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_rst_busy", 64'(bus.busy),          64'd0);
        check("post_rst_addr", 64'(bus.write_address), 64'd0);
        check("post_rst_nwr",  64'(n_wr),              64'd500);
        check("post_rst_wr500", 64'(wr[500]),          64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
